// File: rtl/fir_request_arbiter.sv
// fir_request_arbiter: round-robin sharing of one FIR engine across requesters.
// Optional engine watchdog enabled by defining FIR_ARB_TIMEOUT_EN.
module fir_request_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int DATA_IN_WIDTH  = 32,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clkIn,
  input  logic                                  nResetIn,
  input  logic [REQUESTERS-1:0]                 reqIn,
  input  logic [REQUESTERS*DATA_IN_WIDTH-1:0]   reqDataIn,
  output logic                                  firStartOut,
  output logic [DATA_IN_WIDTH-1:0]              firDataOut,
  input  logic                                  firDoneIn,
  input  logic [DATA_OUT_WIDTH-1:0]             firDataIn,
  output logic [REQUESTERS-1:0]                 doneOut,
  output logic [DATA_OUT_WIDTH-1:0]             dataOut,
  output logic                                  busyOut,
  output logic [REQUESTERS-1:0]                 overrunOut,
  input  logic                                  overrunClearIn,
  output logic                                  timeoutOut
);

  localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  if (REQUESTERS < 2 || REQUESTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fir_request_arbiter: illegal parameter set");
  end

  state_t                     r_state;
  logic [DATA_IN_WIDTH-1:0]   r_slot [REQUESTERS];
  logic [REQUESTERS-1:0]      r_pending;
  logic [REQUESTERS-1:0]      r_overrun;
  logic [GW-1:0]              r_last;
  logic [GW-1:0]              r_grant;
  logic                       r_start;
  logic [DATA_IN_WIDTH-1:0]   r_fdata;
  logic [REQUESTERS-1:0]      r_done;
  logic [DATA_OUT_WIDTH-1:0]  r_data;

  logic                       w_found;
  logic [GW-1:0]              w_next;
  logic [GW-1:0]              w_idx;
  logic                       w_take;
  logic [REQUESTERS-1:0]      w_take_oh;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    w_idx   = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      w_idx = GW'((int'(r_last) + k) % REQUESTERS);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  assign w_take    = (r_state == S_IDLE) && w_found;
  assign w_take_oh = w_take ? (REQUESTERS'(1) << w_next) : '0;

  // Job slots: latest post wins; a re-post before grant flags an overrun.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      for (int i = 0; i < REQUESTERS; i++) r_slot[i] <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (reqIn[i])
          r_slot[i] <= reqDataIn[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        if (reqIn[i])
          r_pending[i] <= 1'b1;
        else if (w_take_oh[i])
          r_pending[i] <= 1'b0;
        if (overrunClearIn)
          r_overrun[i] <= 1'b0;
        else if (reqIn[i] && r_pending[i] && !w_take_oh[i])
          r_overrun[i] <= 1'b1;
      end
    end
  end

`ifdef FIR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_tmo;
  assign timeoutOut = r_tmo;
`else
  assign timeoutOut = 1'b0;
`endif

  // Engine sequencing: grant, start pulse, wait for done, report to owner.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      r_state <= S_IDLE;
      r_last  <= GW'(REQUESTERS - 1);
      r_grant <= '0;
      r_start <= 1'b0;
      r_fdata <= '0;
      r_done  <= '0;
      r_data  <= '0;
`ifdef FIR_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
`ifdef FIR_ARB_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_START;
            r_grant <= w_next;
            r_last  <= w_next;
            r_fdata <= r_slot[w_next];
            r_start <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef FIR_ARB_TIMEOUT_EN
          r_tcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (firDoneIn) begin
            r_data  <= firDataIn;
            r_done  <= REQUESTERS'(1) << r_grant;
            r_state <= S_DONE;
          end
`ifdef FIR_ARB_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign firStartOut = r_start;
  assign firDataOut  = r_fdata;
  assign doneOut     = r_done;
  assign dataOut     = r_data;
  assign busyOut     = (r_state != S_IDLE);
  assign overrunOut  = r_overrun;

endmodule

// File: tb/tb_fir_request_arbiter.sv
// tb_fir_request_arbiter: scoreboard bench for fir_request_arbiter.
// Start/done monitors pop expectations queued by the directed stimulus.
module tb_fir_request_arbiter;

  localparam int R  = 2;
  localparam int DW = 32;
  localparam int OW = 64;

  logic            clk = 1'b0;
  logic            nResetIn;
  logic [R-1:0]    reqIn;
  logic [R*DW-1:0] reqDataIn;
  logic            firStartOut;
  logic [DW-1:0]   firDataOut;
  logic            firDoneIn;
  logic [OW-1:0]   firDataIn;
  logic [R-1:0]    doneOut;
  logic [OW-1:0]   dataOut;
  logic            busyOut;
  logic [R-1:0]    overrunOut;
  logic            overrunClearIn;
  logic            timeoutOut;

  always #5 clk = ~clk;

  fir_request_arbiter #(
    .REQUESTERS(R), .DATA_IN_WIDTH(DW),
    .DATA_OUT_WIDTH(OW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clkIn(clk), .nResetIn(nResetIn),
    .reqIn(reqIn), .reqDataIn(reqDataIn),
    .firStartOut(firStartOut), .firDataOut(firDataOut),
    .firDoneIn(firDoneIn), .firDataIn(firDataIn),
    .doneOut(doneOut), .dataOut(dataOut),
    .busyOut(busyOut), .overrunOut(overrunOut),
    .overrunClearIn(overrunClearIn), .timeoutOut(timeoutOut)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]   exp_start [$];
  logic [R+OW-1:0] exp_done  [$];
  logic [OW-1:0]   eng_res   [$];
  int              lat    = 3;
  bit              silent = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic exp_job(input logic [DW-1:0] d,
                         input logic [R-1:0] who,
                         input logic [OW-1:0] res);
    exp_start.push_back(d);
    exp_done.push_back({who, res});
    eng_res.push_back(res);
  endtask

  // Engine model: answers each start after lat cycles unless silent.
  initial begin
    firDoneIn = 1'b0;
    firDataIn = '0;
    forever begin
      @(negedge clk);
      if (nResetIn && firStartOut && !silent) begin
        repeat (lat) @(negedge clk);
        if (eng_res.size() == 0) begin
          bad("engine_no_result");
          firDataIn = '0;
        end else begin
          firDataIn = eng_res.pop_front();
        end
        firDoneIn = 1'b1;
        @(negedge clk);
        firDoneIn = 1'b0;
      end
    end
  end

  // Monitor: every start and every done must match the head expectation.
  always @(negedge clk) begin
    if (nResetIn) begin
      if (firStartOut) begin
        if (exp_start.size() == 0)
          bad($sformatf("start_unexpected actual=%h required=none",
                        firDataOut));
        else
          chk("start_data", firDataOut, exp_start.pop_front());
      end
      if (doneOut != '0) begin
        if (exp_done.size() == 0) begin
          bad($sformatf("done_unexpected actual=%b required=none",
                        doneOut));
        end else begin
          logic [R+OW-1:0] e;
          e = exp_done.pop_front();
          chk("done_vec", doneOut, e[OW +: R]);
          chk("done_data", dataOut, e[OW-1:0]);
        end
      end
    end
  end

  task automatic pulse(input logic [R-1:0] m, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1);
    reqIn     = m;
    reqDataIn = {d1, d0};
    @(negedge clk);
    reqIn = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_start.size() != 0 || exp_done.size() != 0 || busyOut)
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) bad("idle_wait_expired");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    nResetIn = 1'b0;
    exp_start.delete();
    exp_done.delete();
    eng_res.delete();
    repeat (2) @(negedge clk);
    nResetIn = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, firStartOut, 0);
    chk({tag, "_fdata"}, firDataOut, 0);
    chk({tag, "_done"}, doneOut, 0);
    chk({tag, "_data"}, dataOut, 0);
    chk({tag, "_busy"}, busyOut, 0);
    chk({tag, "_ovr"}, overrunOut, 0);
    chk({tag, "_tmo"}, timeoutOut, 0);
  endtask

  initial begin
    #400000;
    bad("global_time_limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    nResetIn       = 1'b0;
    reqIn          = '0;
    reqDataIn      = '0;
    overrunClearIn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    nResetIn = 1'b1;
    @(negedge clk);

    // Single job, two-cycle start latency.
    exp_job(32'h0001_0002, 2'b01, 64'h1122_3344_5566_7788);
    reqIn     = 2'b01;
    reqDataIn = {32'h0, 32'h0001_0002};
    @(negedge clk);
    reqIn = '0;
    chk("lat_e1_start", firStartOut, 0);
    @(negedge clk);
    chk("lat_e2_start", firStartOut, 1);
    chk("lat_e2_busy", busyOut, 1);
    wait_idle();
    chk("data_hold", dataOut, 64'h1122_3344_5566_7788);

    // Simultaneous pair from reset, then rotation.
    do_reset();
    exp_job(32'h0A0A_0001, 2'b01, 64'hA1);
    exp_job(32'h0B0B_0002, 2'b10, 64'hB2);
    pulse(2'b11, 32'h0A0A_0001, 32'h0B0B_0002);
    wait_idle();
    exp_job(32'h0C0C_0003, 2'b01, 64'hC3);
    pulse(2'b01, 32'h0C0C_0003, 32'h0);
    wait_idle();
    exp_job(32'h0D0D_0011, 2'b10, 64'hD11);
    exp_job(32'h0D0D_0010, 2'b01, 64'hD10);
    pulse(2'b11, 32'h0D0D_0010, 32'h0D0D_0011);
    wait_idle();

    // Overrun: requester 1 posts twice while requester 0 is in WAIT.
    lat = 10;
    exp_job(32'h0E0E_0000, 2'b01, 64'hE0);
    exp_job(32'hBBBB_0000, 2'b10, 64'hBB);
    pulse(2'b01, 32'h0E0E_0000, 32'h0);
    repeat (4) @(negedge clk);
    pulse(2'b10, 32'h0, 32'hAAAA_0000);
    pulse(2'b10, 32'h0, 32'hBBBB_0000);
    chk("ovr_set", overrunOut, 2'b10);
    wait_idle();
    chk("ovr_sticky", overrunOut, 2'b10);
    overrunClearIn = 1'b1;
    @(negedge clk);
    overrunClearIn = 1'b0;
    chk("ovr_clear", overrunOut, 2'b00);

    // Clear wins over a simultaneous overrun set.
    exp_job(32'h0F0F_0000, 2'b01, 64'hF0);
    exp_job(32'h6262_0000, 2'b10, 64'h62);
    pulse(2'b01, 32'h0F0F_0000, 32'h0);
    repeat (4) @(negedge clk);
    pulse(2'b10, 32'h0, 32'h6161_0000);
    chk("ovr_first_post", overrunOut, 2'b00);
    overrunClearIn = 1'b1;
    pulse(2'b10, 32'h0, 32'h6262_0000);
    overrunClearIn = 1'b0;
    chk("ovr_clear_prio", overrunOut, 2'b00);
    wait_idle();
    lat = 3;

    // Re-post on the grant edge: old data first, new data follows.
    do_reset();
    exp_job(32'h4848_0001, 2'b01, 64'h481);
    exp_job(32'h4848_0002, 2'b01, 64'h482);
    reqIn     = 2'b01;
    reqDataIn = {32'h0, 32'h4848_0001};
    @(negedge clk);
    reqDataIn = {32'h0, 32'h4848_0002};
    @(negedge clk);
    reqIn = '0;
    wait_idle();
    chk("grant_edge_ovr", overrunOut, 2'b00);

`ifdef FIR_ARB_TIMEOUT_EN
    // Silent engine: watchdog drops the job and the next one starts.
    begin
      int n;
      do_reset();
      silent = 1'b1;
      exp_start.push_back(32'h7070_0000);
      exp_job(32'h7171_0000, 2'b10, 64'h71);
      pulse(2'b01, 32'h7070_0000, 32'h0);
      n = 0;
      while (!firStartOut && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) bad("tmo_start_wait_expired");
      pulse(2'b10, 32'h0, 32'h7171_0000);
      n = 1;
      while (!timeoutOut && n < 40) begin
        @(negedge clk);
        n++;
      end
      silent = 1'b0;
      chk("tmo_cycles", n, 17);
      chk("tmo_data_kept", dataOut, 0);
      @(negedge clk);
      chk("tmo_one_cycle", timeoutOut, 0);
      wait_idle();
      chk("tmo_next_data", dataOut, 64'h71);
    end
`endif

    // Reset in WAIT with a job pending: everything drops.
    begin
      int starts;
      do_reset();
      silent = 1'b1;
      exp_start.push_back(32'h5050_0000);
      pulse(2'b01, 32'h5050_0000, 32'h0);
      repeat (4) @(negedge clk);
      pulse(2'b10, 32'h0, 32'h5151_0000);
      nResetIn = 1'b0;
      exp_start.delete();
      exp_done.delete();
      eng_res.delete();
      @(negedge clk);
      chk_all_zero("midrst");
      nResetIn = 1'b1;
      silent   = 1'b0;
      starts   = 0;
      repeat (10) begin
        @(negedge clk);
        if (firStartOut) starts++;
      end
      chk("midrst_no_start", starts, 0);
      exp_job(32'h5252_0000, 2'b01, 64'h52);
      pulse(2'b01, 32'h5252_0000, 32'h0);
      wait_idle();
    end

    chk("queues_drained", eng_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
